// File: rtl/datapath_seq.sv
// datapath_seq: register file, A/B/C pipeline registers, B-operand shifter,
// ALU and {V,N,Z} status register with a built-in micro-sequencer. A single
// start/ready handshake runs a whole instruction.
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   start / ready       instruction handshake (accepted when both are high)
//   cmd                 000 ALU, 001 MOV, 010 MOVI, 011 CMP, 100 LDM, else no-op
//   alu_op              00 ADD, 01 SUB, 10 AND, 11 NOT(B)
//   shift               00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B only)
//   use_imm             B operand is imm instead of shifted Rm (ALU/CMP)
//   rd, rn, rm          destination / first source / second source indices
//   imm                 immediate (MOVI value or B operand)
//   mdata               memory read data, sampled at the closing edge of WB
//   done                one-cycle pulse in the final cycle of an instruction
//   result              C register
//   flags               {V,N,Z} status register
//   dbg_sel / dbg_data  combinational register-file read port
module datapath_seq #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [2:0]       cmd,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       shift,
  input  logic             use_imm,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mdata,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] CMD_ALU  = 3'b000;
  localparam logic [2:0] CMD_MOV  = 3'b001;
  localparam logic [2:0] CMD_MOVI = 3'b010;
  localparam logic [2:0] CMD_CMP  = 3'b011;
  localparam logic [2:0] CMD_LDM  = 3'b100;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LA, S_LB, S_EX, S_WB} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [1:0]       shift_q, shift_d;
  logic             use_imm_q, use_imm_d;
  logic [RW-1:0]    rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]       flags_q, flags_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  // ALU datapath
  logic [WIDTH-1:0] a_in, b_sh, b_in, alu_res;
  logic [1:0]       op;
  logic             alu_v;

  always_comb begin
    // MOV passes shift(Rm) through the adder with a zero A operand.
    a_in = (cmd_q == CMD_MOV) ? '0 : a_q;
    case (shift_q)
      SH_LSL:  b_sh = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR:  b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_sh = b_q;
    endcase
    b_in = (use_imm_q && (cmd_q != CMD_MOV)) ? imm_q : b_sh;
    op = alu_op_q;
    if (cmd_q == CMD_MOV) op = OP_ADD;
    if (cmd_q == CMD_CMP) op = OP_SUB;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = a_in + b_in;
        // Overflow: operands share a sign that the sum does not.
        alu_v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a_in - b_in;
        alu_v = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND:  alu_res = a_in & b_in;
      default: alu_res = ~b_in;
    endcase
  end

  // Sequencer and next-state datapath
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cmd_d     = cmd_q;
    alu_op_d  = alu_op_q;
    shift_d   = shift_q;
    use_imm_d = use_imm_q;
    rd_d      = rd_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    flags_d   = flags_q;
    regs_d    = regs_q;
    ready     = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          cmd_d     = cmd;
          alu_op_d  = alu_op;
          shift_d   = shift;
          use_imm_d = use_imm;
          rd_d      = rd;
          rn_d      = rn;
          rm_d      = rm;
          imm_d     = imm;
          case (cmd)
            CMD_ALU, CMD_CMP: state_d = S_LA;
            CMD_MOV:          state_d = S_LB;
            default:          state_d = S_WB;  // MOVI, LDM and no-ops
          endcase
        end
      end
      S_LA: begin
        a_d     = regs_q[rn_q];
        state_d = S_LB;
      end
      S_LB: begin
        b_d     = regs_q[rm_q];
        state_d = S_EX;
      end
      S_EX: begin
        if (cmd_q != CMD_CMP) c_d = alu_res;
        if (cmd_q != CMD_MOV) flags_d = {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
        if (cmd_q == CMD_CMP) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
        case (cmd_q)
          CMD_ALU, CMD_MOV: regs_d[rd_q] = c_q;
          CMD_MOVI:         regs_d[rd_q] = imm_q;
          CMD_LDM:          regs_d[rd_q] = mdata;
          default:          ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      alu_op_q  <= '0;
      shift_q   <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      flags_q   <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      alu_op_q  <= alu_op_d;
      shift_q   <= shift_d;
      use_imm_q <= use_imm_d;
      rd_q      <= rd_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      flags_q   <= flags_d;
      regs_q    <= regs_d;
    end
  end

  assign result   = c_q;
  assign flags    = flags_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed scenarios followed by random
// instructions, compared against an arithmetic reference model. A second
// instance (WIDTH=8, NREG=16) covers the narrow-width wrap case.
module tb_datapath_seq;

  localparam int W    = 16;
  localparam int N    = 8;
  localparam int MASK = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, ready, use_imm, done;
  logic [2:0]  cmd, flags;
  logic [1:0]  alu_op, shift;
  logic [2:0]  rd, rn, rm, dbg_sel;
  logic [15:0] imm, mdata, result, dbg_data;

  logic        b_start, b_ready, b_done;
  logic [2:0]  b_cmd, b_flags;
  logic [3:0]  b_rd, b_rn, b_rm, b_dbg_sel;
  logic [7:0]  b_imm, b_result, b_dbg_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_r [N];
  int         m_c;
  logic [2:0] m_f;

  always #10 clk = ~clk;

  datapath_seq #(.WIDTH(16), .NREG(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .cmd(cmd),
    .alu_op(alu_op), .shift(shift), .use_imm(use_imm), .rd(rd), .rn(rn), .rm(rm),
    .imm(imm), .mdata(mdata), .done(done), .result(result), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  datapath_seq #(.WIDTH(8), .NREG(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .ready(b_ready), .cmd(b_cmd),
    .alu_op(2'b00), .shift(2'b00), .use_imm(1'b0), .rd(b_rd), .rn(b_rn), .rm(b_rm),
    .imm(b_imm), .mdata(8'h00), .done(b_done), .result(b_result), .flags(b_flags),
    .dbg_sel(b_dbg_sel), .dbg_data(b_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic int shifted(input int v, input logic [1:0] sh);
    case (sh)
      2'b01:   return (v * 2) & MASK;
      2'b10:   return v / 2;
      2'b11:   return (sx(v) >>> 1) & MASK;
      default: return v;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] c);
    case (c)
      3'b000:         return 4;
      3'b001, 3'b011: return 3;
      default:        return 1;
    endcase
  endfunction

  // Architectural effect of one instruction on the model.
  task automatic model_exec(input logic [2:0] c, input int rd_i, rn_i, rm_i,
                            input logic [1:0] op, sh, input logic ui, input int imm_i, md);
    int a, b, s, res;
    logic v;
    a = m_r[rn_i];
    b = ui ? imm_i : shifted(m_r[rm_i], sh);
    v = 1'b0;
    if (c == 3'b011) op = 2'b01;
    case (op)
      2'b00:   begin s = sx(a) + sx(b); v = (s > 32767) || (s < -32768); end
      2'b01:   begin s = sx(a) - sx(b); v = (s > 32767) || (s < -32768); end
      2'b10:   s = a & b;
      default: s = ~b;
    endcase
    res = s & MASK;
    case (c)
      3'b000: begin m_r[rd_i] = res; m_c = res; m_f = {v, res[W-1], res == 0}; end
      3'b001: begin m_r[rd_i] = shifted(m_r[rm_i], sh); m_c = m_r[rd_i]; end
      3'b010: m_r[rd_i] = imm_i;
      3'b011: m_f = {v, res[W-1], res == 0};
      3'b100: m_r[rd_i] = md;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_r[i] = 0;
    m_c = 0;
    m_f = 3'b000;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_result"}, result, m_c);
    check({tag, "_flags"}, flags, m_f);
    for (int i = 0; i < N; i++) begin
      dbg_sel = i[2:0];
      #1;
      check($sformatf("%s_R%0d", tag, i), dbg_data, m_r[i]);
    end
    @(negedge clk);
  endtask

  // Run one instruction; entered and left on a falling edge.
  task automatic do_instr(input string tag, input logic [2:0] c, input int rd_i, rn_i, rm_i,
                          input logic [1:0] op, sh, input logic ui, input int imm_i, md,
                          input bit poke);
    int cyc, lat;
    cyc = 0;
    while (!ready && cyc < 20) begin @(negedge clk); cyc++; end
    check({tag, "_ready_in"}, ready, 1'b1);
    cmd = c; rd = rd_i[2:0]; rn = rn_i[2:0]; rm = rm_i[2:0];
    alu_op = op; shift = sh; use_imm = ui; imm = imm_i[15:0];
    mdata = ~md[15:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Operands are held internally; disturb every input after acceptance.
    cmd = 3'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
    alu_op = 2'($urandom); shift = 2'($urandom); use_imm = 1'($urandom); imm = 16'($urandom);
    mdata = md[15:0];
    lat = latency(c);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      start = poke && (k == 1);
      check($sformatf("%s_done_c%0d", tag, k), done, k == lat);
      check($sformatf("%s_busy_c%0d", tag, k), ready, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_after"}, done, 1'b0);
    check({tag, "_ready_after"}, ready, 1'b1);
    model_exec(c, rd_i, rn_i, rm_i, op, sh, ui, imm_i, md);
    check_state(tag);
  endtask

  task automatic b_run(input string tag, input logic [2:0] c, input logic [3:0] rd_i, rn_i, rm_i,
                       input logic [7:0] imm_i, input int lat);
    int cyc;
    b_cmd = c; b_rd = rd_i; b_rn = rn_i; b_rm = rm_i; b_imm = imm_i;
    b_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 10) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, cyc, lat);
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; cmd = '0; alu_op = '0; shift = '0; use_imm = 1'b0;
    rd = '0; rn = '0; rm = '0; imm = '0; mdata = '0; dbg_sel = '0;
    b_start = 1'b0; b_cmd = '0; b_rd = '0; b_rn = '0; b_rm = '0; b_imm = '0; b_dbg_sel = '0;
    model_reset();

    // T1 reset
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("T1_ready", ready, 1'b1);
    check("T1_done", done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      b_dbg_sel = i[3:0];
      #1;
      check($sformatf("T1_B_R%0d", i), b_dbg_data, 8'h00);
    end
    check_state("T1");
    reset_n = 1'b1;

    // T2 MOVI + ALU ADD with LSL1 on B
    do_instr("T2_movi0", 3'b010, 0, 0, 0, 2'b00, 2'b00, 1'b0, 7, 0, 1'b0);
    do_instr("T2_movi1", 3'b010, 1, 0, 0, 2'b00, 2'b00, 1'b0, 2, 0, 1'b0);
    do_instr("T2_add", 3'b000, 2, 0, 1, 2'b00, 2'b01, 1'b0, 0, 0, 1'b0);
    dbg_sel = 3'd2; #1;
    check("T2_R2_const", dbg_data, 16'd11);
    check("T2_flags_const", flags, 3'b000);
    @(negedge clk);

    // T3 signed overflow, then CMP equal
    do_instr("T3_movi0", 3'b010, 0, 0, 0, 2'b00, 2'b00, 1'b0, 16'h7FFF, 0, 1'b0);
    do_instr("T3_movi1", 3'b010, 1, 0, 0, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
    do_instr("T3_add", 3'b000, 2, 0, 1, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);
    check("T3_result_const", result, 16'h8000);
    check("T3_flags_const", flags, 3'b110);
    do_instr("T3_cmp", 3'b011, 7, 1, 1, 2'b10, 2'b00, 1'b0, 0, 0, 1'b0);
    check("T3_cmp_flags_const", flags, 3'b001);

    // T4 MOV with ASR1; start pulsed while busy
    do_instr("T4_movi4", 3'b010, 4, 0, 0, 2'b00, 2'b00, 1'b0, 16'h8004, 0, 1'b0);
    do_instr("T4_mov", 3'b001, 3, 5, 4, 2'b11, 2'b11, 1'b0, 0, 0, 1'b1);
    dbg_sel = 3'd3; #1;
    check("T4_R3_const", dbg_data, 16'hC002);
    check("T4_flags_const", flags, 3'b001);
    @(negedge clk);

    // T5 LDM, and ALU with rd == rn using an immediate
    do_instr("T5_ldm", 3'b100, 5, 0, 0, 2'b00, 2'b00, 1'b0, 0, 16'hBEEF, 1'b0);
    do_instr("T5_movi2", 3'b010, 2, 0, 0, 2'b00, 2'b00, 1'b0, 3, 0, 1'b0);
    do_instr("T5_alias", 3'b000, 2, 2, 1, 2'b00, 2'b00, 1'b1, 4, 0, 1'b0);
    dbg_sel = 3'd5; #1;
    check("T5_R5_const", dbg_data, 16'hBEEF);
    dbg_sel = 3'd2; #1;
    check("T5_R2_const", dbg_data, 16'd7);
    @(negedge clk);

    // Random instructions (including undefined commands)
    for (int n = 0; n < 150; n++) begin
      do_instr($sformatf("RND%0d", n), 3'($urandom_range(0, 7)),
               $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
               2'($urandom), 2'($urandom), 1'($urandom),
               $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 3) == 0);
    end

    // T6 reset during EX of an ALU op targeting R6
    do_instr("T6_movi6", 3'b010, 6, 0, 0, 2'b00, 2'b00, 1'b0, 16'h1234, 0, 1'b0);
    cmd = 3'b000; rd = 3'd6; rn = 3'd0; rm = 3'd1; alu_op = 2'b00; shift = 2'b00; use_imm = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("T6_done_c%0d", k), done, 1'b0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("T6_done_reset", done, 1'b0);
    check("T6_ready_reset", ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("T6_done_post", done, 1'b0);
    check("T6_ready_post", ready, 1'b1);
    model_reset();
    check_state("T6");

    // Narrow instance: 8'hFF + 1 wraps to zero
    b_run("B_movi15", 3'b010, 4'd15, 4'd0, 4'd0, 8'hFF, 1);
    b_run("B_movi9", 3'b010, 4'd9, 4'd0, 4'd0, 8'h01, 1);
    b_run("B_add", 3'b000, 4'd10, 4'd15, 4'd9, 8'h00, 4);
    check("B_result", b_result, 8'h00);
    check("B_flags", b_flags, 3'b001);
    b_dbg_sel = 4'd10; #1;
    check("B_R10", b_dbg_data, 8'h00);
    b_dbg_sel = 4'd15; #1;
    check("B_R15", b_dbg_data, 8'hFF);
    check("B_ready", b_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
